// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   - FSM state encodings (plain localparam constants)
//   - grant_id_width(): width of a requester index for a given requester count
package uart_tx_arbiter_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_GRANT     = 3'd1;
    localparam logic [2:0] ST_LAUNCH    = 3'd2;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd3;
    localparam logic [2:0] ST_WAIT_DONE = 3'd4;

    localparam int DEFAULT_NUM_REQ = 4;

    function automatic int grant_id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEFAULT_ID_W = grant_id_width(DEFAULT_NUM_REQ);

endpackage

// File: rtl/uart_tx_arbiter_rr_priority_pick.sv
// Combinational round-robin pick.
//   req       : request vector, one bit per requester
//   ptr       : index that has highest priority this round (must be < NUM_REQ)
//   winner    : first requester at or above ptr (wrapping) with its bit set
//   any_valid : at least one request bit is set
module rr_priority_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int ID_W   = grant_id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    winner,
    output logic               any_valid
);

    always_comb begin
        logic found;
        int   idx;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // Modulo by subtraction keeps this valid for non-power-of-two counts.
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx]) begin
                winner = ID_W'(idx);
                found  = 1'b1;
            end
        end
    end

    assign any_valid = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   IDLE       | nothing in flight; waits for a request with the Tx not busy
//   GRANT      | pick winner, ack it, latch its byte, advance the pointer
//   LAUNCH     | one-cycle Tx_Data_Valid pulse, timeout counter cleared
//   WAIT_BUSY  | waiting for Tx_Busy to rise; Err_Timeout after TIMEOUT cycles
//   WAIT_DONE  | frame on the wire; on Tx_Busy low go to GRANT or IDLE
//
// Ports:
//   CLK, RST       clock, asynchronous active-high reset
//   Req_Valid      per-requester byte pending (held until acked)
//   Req_Data       packed bytes, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   Req_Ack        one-hot single-cycle accept pulse (during GRANT)
//   Tx_P_Data      registered byte, stable from GRANT to the next GRANT
//   Tx_Data_Valid  single-cycle launch pulse (during LAUNCH)
//   Tx_Busy        transmitter busy flag
//   Grant_Id       index of the current or last granted requester
//   Active         high whenever the FSM is not IDLE
//   Err_Timeout    single-cycle pulse when Tx_Busy never rose after a launch
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int TIMEOUT    = 4,
    localparam int ID_W      = grant_id_width(NUM_REQ)
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            Req_Valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] Req_Data,
    output logic [NUM_REQ-1:0]            Req_Ack,
    output logic [DATA_WIDTH-1:0]         Tx_P_Data,
    output logic                          Tx_Data_Valid,
    input  logic                          Tx_Busy,
    output logic [ID_W-1:0]               Grant_Id,
    output logic                          Active,
    output logic                          Err_Timeout
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]  PTR_LAST = ID_W'(NUM_REQ - 1);

    logic [2:0]       state;
    logic [ID_W-1:0]  rr_ptr;
    logic [CNT_W-1:0] to_cnt;
    logic [ID_W-1:0]  winner;
    logic             any_valid;
    logic             to_expire;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req       (Req_Valid),
        .ptr       (rr_ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // The Nth consecutive non-busy cycle in WAIT_BUSY is the expiry cycle.
    assign to_expire = (state == ST_WAIT_BUSY) && !Tx_Busy && (to_cnt == CNT_LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            to_cnt    <= '0;
            Tx_P_Data <= '0;
            Grant_Id  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_valid && !Tx_Busy) begin
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // A requester may withdraw between IDLE and GRANT; no ack then.
                    if (any_valid) begin
                        Tx_P_Data <= Req_Data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                        Grant_Id  <= winner;
                        rr_ptr    <= (winner == PTR_LAST) ? '0 : winner + ID_W'(1);
                        state     <= ST_LAUNCH;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_LAUNCH: begin
                    to_cnt <= '0;
                    state  <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (Tx_Busy) begin
                        state <= ST_WAIT_DONE;
                    end else begin
                        to_cnt <= to_cnt + CNT_W'(1);
                        if (to_expire) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_WAIT_DONE: begin
                    if (!Tx_Busy) begin
                        state <= any_valid ? ST_GRANT : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Ack and launch are decoded from distinct states, so they never overlap.
    always_comb begin
        Req_Ack = '0;
        if ((state == ST_GRANT) && any_valid) begin
            Req_Ack[winner] = 1'b1;
        end
    end

    assign Tx_Data_Valid = (state == ST_LAUNCH);
    assign Err_Timeout   = to_expire;
    assign Active        = (state != ST_IDLE);

endmodule
